display_scan_ctrl: RTL and testbench

Digit-scan controller for the four-digit seven-segment display. Generates the 2-bit digit select consumed by the downstream segment decoder, drives the matching active-low anode enable with a blanking gap between digits to suppress ghosting, and accepts new 16-bit display values through a valid/ready handshake, applying each at a frame boundary so a scan never shows a torn value. Sits directly upstream of the segment pattern stage, between the application logic and the display pins.

---
 rtl/display_scan_ctrl_pkg.sv | 23 ++
 rtl/display_scan_ctrl_scan_prescaler.sv | 39 +++
 rtl/display_scan_ctrl.sv | 99 +++++++++
 tb/tb_display_scan_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan path.
package display_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;
  localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef logic [SEL_W-1:0]   digit_idx_t;
  typedef logic [DIGIT_W-1:0] nibble_t;

  function automatic nibble_t get_nibble(input logic [VALUE_W-1:0] value,
                                         input digit_idx_t         idx);
    return value[idx*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_on(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// Slot timing for the digit scan: slot counter, end-of-slot wrap and
// blanking-gap flag, all frozen while the scan is disabled.
module scan_prescaler #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_blank
);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last  = (r_count == CNT_W'(PRESCALE - 1));
  assign o_wrap  = i_enable && w_last;
  assign o_blank = (BLANK_CYCLES != 0) && (int'(r_count) < BLANK_CYCLES);
  assign o_count = r_count;

  // Slot counter: 0 .. PRESCALE-1, holds while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (w_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit display scan controller: digit select, blanked anode drive and
// a valid/ready value path that only updates the display at frame boundaries.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [DIGIT_W-1:0]    digit_val,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0]      w_count;
  logic                  w_wrap;
  logic                  w_blank;
  logic                  w_boundary;
  logic                  w_frame_start;
  logic                  w_accept;

  digit_idx_t            r_dig;
  logic [VALUE_W-1:0]    r_display;
  logic [VALUE_W-1:0]    r_pending;
  logic                  r_ready;
  digit_idx_t            r_digit_sel;
  nibble_t               r_digit_val;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_frame_tick;

  scan_prescaler #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (enable),
    .o_count  (w_count),
    .o_wrap   (w_wrap),
    .o_blank  (w_blank)
  );

  assign w_boundary    = w_wrap && (r_dig == 2'd3);
  assign w_frame_start = enable && (w_count == '0) && (r_dig == 2'd0);
  // r_ready doubles as the inverted pending-full flag
  assign w_accept      = value_valid && r_ready;

  // Digit position, registered outputs and the pending/display value path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig        <= 2'd0;
      r_display    <= 16'h0000;
      r_pending    <= 16'h0000;
      r_ready      <= 1'b1;
      r_digit_sel  <= 2'd0;
      r_digit_val  <= 4'h0;
      r_an_n       <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_dig <= r_dig + 2'd1;
      end else begin
        r_dig <= r_dig;
      end

      r_digit_sel  <= r_dig;
      r_digit_val  <= get_nibble(r_display, r_dig);
      r_an_n       <= (enable && !w_blank) ? anode_on(r_dig) : AN_OFF;
      r_frame_tick <= w_frame_start;

      // A fresh accept on the boundary cycle is not forwarded to the display
      if (w_boundary && !r_ready) begin
        r_display <= r_pending;
        r_ready   <= 1'b1;
      end else if (w_accept) begin
        r_pending <= value_in;
        r_ready   <= 1'b0;
      end else begin
        r_ready   <= r_ready;
      end
    end
  end

  assign value_ready = r_ready;
  assign digit_sel   = r_digit_sel;
  assign digit_val   = r_digit_val;
  assign an_n        = r_an_n;
  assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a position-based reference model.
module tb_display_scan_ctrl;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] value_in;
  logic        value_valid;
  logic        value_ready;
  logic [1:0]  digit_sel;
  logic [3:0]  digit_val;
  logic [3:0]  an_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: absolute enabled-cycle count since reset
  int          pos;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_full;
  logic [1:0]  e_sel;
  logic [3:0]  e_val;
  logic [3:0]  e_an;
  logic        e_tick;
  logic        e_ready;

  always #5 clk = ~clk;

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .digit_sel   (digit_sel),
    .digit_val   (digit_val),
    .an_n        (an_n),
    .frame_tick  (frame_tick)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos     = 0;
    m_disp  = 16'h0000;
    m_pend  = 16'h0000;
    m_full  = 1'b0;
    e_sel   = 2'd0;
    e_val   = 4'h0;
    e_an    = 4'hF;
    e_tick  = 1'b0;
    e_ready = 1'b1;
  endtask

  task automatic model_edge();
    int         cnt;
    int         dig;
    bit         acc;
    bit         bnd;
    logic [3:0] one;
    one   = 4'b0001;
    cnt   = pos % P;
    dig   = (pos / P) % 4;
    e_sel = 2'(dig);
    e_val = 4'((m_disp >> (4 * dig)) & 16'h000F);
    e_an  = (enable && cnt >= B) ? ~(one << dig) : 4'hF;
    e_tick = enable && ((pos % FRAME) == 0);
    acc   = value_valid && !m_full;
    bnd   = enable && ((pos % FRAME) == FRAME - 1);
    if (bnd && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end
    if (acc) begin
      m_pend = value_in;
      m_full = 1'b1;
    end
    e_ready = !m_full;
    if (enable) pos++;
  endtask

  task automatic compare_all();
    check("digit_sel",   16'(digit_sel),   16'(e_sel));
    check("digit_val",   16'(digit_val),   16'(e_val));
    check("an_n",        16'(an_n),        16'(e_an));
    check("frame_tick",  16'(frame_tick),  16'(e_tick));
    check("value_ready", 16'(value_ready), 16'(e_ready));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input int target);
    int budget;
    budget = 3 * FRAME;
    while ((pos % FRAME) != target && budget > 0) begin
      step();
      budget--;
    end
    if ((pos % FRAME) != target) check("wait_pos_timeout", 16'(pos % FRAME), 16'(target));
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    value_valid = 1'b0;
    value_in    = 16'h0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();

    // Basic scan: tick on first enabled cycle, digits every P cycles
    rst_n  = 1'b1;
    enable = 1'b1;
    run(FRAME + 4);

    // Mid-frame offer
    wait_pos(10);
    value_in    = 16'h1234;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    run(2 * FRAME);

    // Offer on the exact boundary cycle with pending empty
    wait_pos(FRAME - 1);
    value_in    = 16'hABCD;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    run(2 * FRAME + 2);

    // Back-to-back offers while pending is full
    wait_pos(5);
    value_in    = 16'h5555;
    value_valid = 1'b1;
    step();
    value_in    = 16'h6666;
    run(2 * FRAME);
    value_valid = 1'b0;
    run(FRAME);

    // Freeze in slot 2, count 5
    wait_pos(2 * P + 5);
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    run(FRAME + 5);

    // Reset mid-slot with a pending value
    wait_pos(12);
    value_in    = 16'h9999;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    run(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    step();
    rst_n = 1'b1;
    run(2 * FRAME + 3);

    // Random traffic with occasional enable drops
    for (int i = 0; i < 800; i++) begin
      value_valid = ($urandom_range(0, 3) == 0);
      value_in    = 16'($urandom);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      step();
    end
    enable      = 1'b1;
    value_valid = 1'b0;
    run(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
